// File: rtl/axil_wr_arbiter.sv
// Per-slave AXI-Lite write-channel arbiter: fixed-priority or round-robin grant,
// held from issue until the slave's B handshake completes.
//
// state | meaning
// IDLE  | no grant held; a non-zero request loads the winner on the next edge
// BUSY  | grant locked; released only by s_bvalid_i & s_bready_i
module axil_wr_arbiter #(
    parameter int NUMBER_MASTER = 32,
    parameter int ARBITER       = 1,
    localparam int ID_WIDTH     = $clog2(NUMBER_MASTER)
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUMBER_MASTER-1:0] req_i,
    input  logic                     s_bvalid_i,
    input  logic                     s_bready_i,
    output logic [NUMBER_MASTER-1:0] grant_o,
    output logic [ID_WIDTH-1:0]      grant_id_o,
    output logic                     grant_vld_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                   state, state_nxt;
    logic [ID_WIDTH-1:0]      rr_ptr, rr_ptr_nxt;
    logic [NUMBER_MASTER-1:0] grant_nxt;
    logic [ID_WIDTH-1:0]      grant_id_nxt;
    logic                     grant_vld_nxt;
    logic                     found;
    logic [ID_WIDTH-1:0]      winner;
    logic [ID_WIDTH-1:0]      winner_inc;

    // Circular search starting at rr_ptr; fixed priority always starts at 0.
    always_comb begin
        int start;
        int idx;
        found  = 1'b0;
        winner = '0;
        start  = (ARBITER != 0) ? int'(rr_ptr) : 0;
        for (int i = 0; i < NUMBER_MASTER; i++) begin
            idx = start + i;
            if (idx >= NUMBER_MASTER) begin
                idx = idx - NUMBER_MASTER;
            end
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = ID_WIDTH'(idx);
            end
        end
        winner_inc = (int'(winner) == NUMBER_MASTER - 1) ? '0 : winner + 1'b1;
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_nxt     = grant_o;
        grant_id_nxt  = grant_id_o;
        grant_vld_nxt = grant_vld_o;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt     = BUSY;
                    grant_nxt     = NUMBER_MASTER'(1) << winner;
                    grant_id_nxt  = winner;
                    grant_vld_nxt = 1'b1;
                    if (ARBITER != 0) begin
                        rr_ptr_nxt = winner_inc;
                    end
                end
            end
            BUSY: begin
                if (s_bvalid_i && s_bready_i) begin
                    state_nxt     = IDLE;
                    grant_nxt     = '0;
                    grant_vld_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                grant_nxt     = '0;
                grant_vld_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_o     <= '0;
            grant_id_o  <= '0;
            grant_vld_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            grant_o     <= grant_nxt;
            grant_id_o  <= grant_id_nxt;
            grant_vld_o <= grant_vld_nxt;
        end
    end

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus;
// both grant/release in lockstep, only the chosen winner differs.
module tb_axil_wr_arbiter;

    localparam int NM = 32;

    logic          clk;
    logic          aresetn;
    logic [NM-1:0] req;
    logic          bvalid;
    logic          bready;
    logic [NM-1:0] grant_rr, grant_fp;
    logic [4:0]    id_rr, id_fp;
    logic          vld_rr, vld_fp;

    int checks = 0;
    int errors = 0;

    axil_wr_arbiter #(.NUMBER_MASTER(NM), .ARBITER(1)) dut_rr (
        .aclk(clk), .aresetn(aresetn), .req_i(req),
        .s_bvalid_i(bvalid), .s_bready_i(bready),
        .grant_o(grant_rr), .grant_id_o(id_rr), .grant_vld_o(vld_rr)
    );

    axil_wr_arbiter #(.NUMBER_MASTER(NM), .ARBITER(0)) dut_fp (
        .aclk(clk), .aresetn(aresetn), .req_i(req),
        .s_bvalid_i(bvalid), .s_bready_i(bready),
        .grant_o(grant_fp), .grant_id_o(id_fp), .grant_vld_o(vld_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rst_n;
        logic [NM-1:0] req;
        logic          bv;
        logic          br;
        logic          vld;
        logic [4:0]    id_rr;
        logic [4:0]    id_fp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic rst_n, input logic [NM-1:0] r,
                       input logic bv, input logic br, input logic vld,
                       input logic [4:0] irr, input logic [4:0] ifp);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.req = r; v.bv = bv; v.br = br;
        v.vld = vld; v.id_rr = irr; v.id_fp = ifp;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic rst_n, input logic [NM-1:0] r, input logic bv, input logic br);
        aresetn = rst_n;
        req     = r;
        bvalid  = bv;
        bready  = br;
        @(posedge clk);
        #1;
    endtask

    task automatic check_one(input string name, input string which, input logic vld,
                             input logic [4:0] id, input logic [NM-1:0] g,
                             input logic exp_vld, input logic [4:0] exp_id);
        logic [NM-1:0] exp_g;
        exp_g = exp_vld ? (NM'(1) << exp_id) : '0;
        checks++;
        if (vld !== exp_vld) begin
            errors++;
            $display("FAIL %s %s grant_vld: got %0b expected %0b", name, which, vld, exp_vld);
        end
        checks++;
        if (g !== exp_g) begin
            errors++;
            $display("FAIL %s %s grant: got %h expected %h", name, which, g, exp_g);
        end
        if (exp_vld) begin
            checks++;
            if (id !== exp_id) begin
                errors++;
                $display("FAIL %s %s grant_id: got %0d expected %0d", name, which, id, exp_id);
            end
        end
    endtask

    task automatic check(input string name, input logic exp_vld,
                         input logic [4:0] exp_rr, input logic [4:0] exp_fp);
        check_one(name, "rr", vld_rr, id_rr, grant_rr, exp_vld, exp_rr);
        check_one(name, "fp", vld_fp, id_fp, grant_fp, exp_vld, exp_fp);
    endtask

    task automatic step(input string name, input logic rst_n, input logic [NM-1:0] r,
                        input logic bv, input logic br, input logic vld,
                        input logic [4:0] irr, input logic [4:0] ifp);
        apply(rst_n, r, bv, br);
        check(name, vld, irr, ifp);
    endtask

    initial begin
        aresetn = 1'b0;
        req     = '0;
        bvalid  = 1'b0;
        bready  = 1'b0;

        // Reset, first grant, hold, and fixed-priority versus round-robin contention.
        add("rst0",        1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0);
        add("rst1",        1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0);
        add("first_grant", 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b1, 5'd4,  5'd4);
        for (int i = 0; i < 5; i++)
            add("hold_noreq",  1'b1, 32'h0,     1'b0, 1'b0, 1'b1, 5'd4,  5'd4);
        for (int i = 0; i < 3; i++)
            add("hold_bvalid", 1'b1, 32'h0,     1'b1, 1'b0, 1'b1, 5'd4,  5'd4);
        add("release",     1'b1, 32'h0,         1'b1, 1'b1, 1'b0, 5'd0,  5'd0);
        add("idle_noreq",  1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  5'd0);
        add("prio_a",      1'b1, 32'h8000_0006, 1'b0, 1'b0, 1'b1, 5'd31, 5'd1);
        add("gap_a",       1'b1, 32'h8000_0006, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0);
        add("prio_b",      1'b1, 32'h8000_0006, 1'b0, 1'b0, 1'b1, 5'd1,  5'd1);
        add("gap_b",       1'b1, 32'h8000_0006, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0);
        add("prio_c",      1'b1, 32'h8000_0006, 1'b0, 1'b0, 1'b1, 5'd2,  5'd1);
        add("gap_c",       1'b1, 32'h8000_0006, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0);
        add("prio_d",      1'b1, 32'h8000_0006, 1'b0, 1'b0, 1'b1, 5'd31, 5'd1);
        add("gap_d",       1'b1, 32'h8000_0006, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0);
        add("only31",      1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 5'd31, 5'd31);
        add("gap_e",       1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0);

        foreach (vecs[i])
            step(vecs[i].name, vecs[i].rst_n, vecs[i].req, vecs[i].bv, vecs[i].br,
                 vecs[i].vld, vecs[i].id_rr, vecs[i].id_fp);

        // Full round-robin rotation from a fresh pointer, one idle cycle between grants.
        step("rr_reset", 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        for (int k = 0; k <= NM; k++) begin
            step("rr_rot", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'(k % NM), 5'd0);
            step("rr_gap", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        end

        // Pointer lands on 31, then a request at 0 and 2 must wrap to 0 first.
        step("grant30",  1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b1, 5'd30, 5'd30);
        step("gap30",    1'b1, 32'h0,         1'b1, 1'b1, 1'b0, 5'd0,  5'd0);
        step("wrap0",    1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0);
        step("gapw0",    1'b1, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0);
        step("wrap2",    1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 5'd2,  5'd0);
        step("gapw2",    1'b1, 32'h0,         1'b1, 1'b1, 1'b0, 5'd0,  5'd0);

        // Reset while busy drops the grant and clears the pointer.
        step("grant7",   1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b1, 5'd7,  5'd7);
        step("busy7",    1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 5'd7,  5'd7);
        step("midrst",   1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0);
        step("postrst",  1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0);
        step("postgap",  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0);
        step("postnext", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd1,  5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
